fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter PORT_NUM, default 14, number of input FIFOs served.
REQ-002 Parameter DATA_W, default 32, FIFO word width.
REQ-003 Parameter MAX_LEN, default 256, maximum packet length in words before forced termination.
REQ-004 glb_clk  input  1  single clock; all state changes on rising edge.
REQ-005 glb_areset_n  input  1  asynchronous active-low reset.
REQ-006 fifo_sel_res_final  input  8  selection code: bit7=valid, bits[6:0]=FIFO index; 8'd0 = no selection.
REQ-007 fifo_empty  input  PORT_NUM  per-FIFO empty flag, bit i for FIFO i.
REQ-008 fifo_rd_data  input  PORT_NUM*DATA_W  show-ahead head words; FIFO i occupies bits [i*DATA_W +: DATA_W].
REQ-009 fifo_rd_eop  input  PORT_NUM  show-ahead end-of-packet flag of each head word.
REQ-010 fifo_rd_en  output  PORT_NUM  one-hot pop strobe; head word consumed on the edge where bit is high.
REQ-011 out_data  output  DATA_W  registered packet word.
REQ-012 out_valid  output  1  out_data/out_eop valid.
REQ-013 out_eop  output  1  last word of packet.
REQ-014 out_ready  input  1  downstream accepts word when out_valid && out_ready.
REQ-015 pkt_busy  output  1  high in every state except IDLE.
REQ-016 pkt_done  output  1  one-cycle pulse at packet completion.
REQ-017 pkt_err  output  1  one-cycle pulse on invalid index or length overrun.

Function
REQ-018 States: IDLE, XFER, DONE; reset state IDLE.
REQ-019 IDLE -> XFER when fifo_sel_res_final[7]=1 and fifo_sel_res_final[6:0] < PORT_NUM; index latched into cur_idx on that edge.
REQ-020 IDLE with bit7=1 and index >= PORT_NUM: stay IDLE, pkt_err pulses next cycle, no pop.
REQ-021 Selection input ignored in XFER and DONE; changes mid-packet have no effect.
REQ-022 In XFER, pop condition = !fifo_empty[cur_idx] && (!out_valid || out_ready); fifo_rd_en[cur_idx] = pop (combinational), all other bits 0.
REQ-023 fifo_rd_en is 0 in IDLE and DONE.
REQ-024 On pop edge: out_data <= head word of cur_idx, out_eop <= head eop flag, out_valid <= 1; word counter increments.
REQ-025 No pop and out_ready high: out_valid <= 0; no pop and out_ready low: output register holds.
REQ-026 Full throughput: one word per cycle while FIFO non-empty and out_ready high.
REQ-027 Pop of a word with eop=1: XFER -> DONE; counter cleared.
REQ-028 Pop of word number MAX_LEN (counter = MAX_LEN-1 before pop) with eop=0: out_eop forced 1, pkt_err pulses, XFER -> DONE; remaining words of that packet stay in FIFO.
REQ-029 Word counter width clog2(MAX_LEN)+1; never wraps.
REQ-030 DONE lasts exactly one cycle: pkt_done=1, then -> IDLE; a still-valid selection is taken from IDLE on the following edge (min 2-cycle inter-packet gap).
REQ-031 FIFO empty in XFER: no pop, remain XFER indefinitely; no timeout.
REQ-032 pkt_done and pkt_err are registered, mutually independent; both may be high in the same cycle (overrun case).

Reset
REQ-033 glb_areset_n low asynchronously forces: state IDLE, cur_idx 0, counter 0, out_data 0, out_valid 0, out_eop 0, pkt_done 0, pkt_err 0; fifo_rd_en 0 and pkt_busy 0 as a consequence.
REQ-034 Reset mid-packet discards the partial packet; no further pops until a new selection after reset release.
REQ-035 Reset deassertion is synchronized externally; first edge after release samples fifo_sel_res_final normally.

Verification
REQ-036 sel=8'd131, FIFO3 holds 4 words, last eop, out_ready=1 -> fifo_rd_en=14'h0008 for 4 consecutive cycles, out_valid 4 cycles, out_eop on 4th, pkt_done one cycle later.
REQ-037 Same packet, out_ready toggles 1,0,1,0 -> each word held while out_ready=0, no pop while out_valid && !out_ready, words in order, no loss/duplication.
REQ-038 sel=8'd143 (index 15) -> no pop, pkt_err pulse, pkt_busy stays 0.
REQ-039 FIFO0, 300 words without eop, MAX_LEN=256 -> exactly 256 pops, word 256 out_eop=1, pkt_err and pkt_done pulse together, 44 words remain.
REQ-040 Reset asserted after 2 of 5 words of FIFO7 -> all outputs 0 immediately, fifo_rd_en=0, state IDLE after release.
REQ-041 sel switches 8'd130 -> 8'd133 mid-packet -> packet from FIFO2 completes; FIFO5 served only after DONE/IDLE.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: drains one packet from the selected show-ahead FIFO into a
// registered valid/ready output stage.
//   glb_clk, glb_areset_n       : clock, async active-low reset
//   fifo_sel_res_final          : [7]=valid, [6:0]=FIFO index
//   fifo_empty/rd_data/rd_eop   : per-FIFO show-ahead head state
//   fifo_rd_en                  : one-hot pop strobe
//   out_data/out_valid/out_eop  : registered output word, out_ready accepts
//   pkt_busy/pkt_done/pkt_err   : packet status
module fifo_rd_ctrl #(
  parameter int PORT_NUM = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_LEN  = 256
) (
  input  logic                       glb_clk,
  input  logic                       glb_areset_n,
  input  logic [7:0]                 fifo_sel_res_final,
  input  logic [PORT_NUM-1:0]        fifo_empty,
  input  logic [PORT_NUM*DATA_W-1:0] fifo_rd_data,
  input  logic [PORT_NUM-1:0]        fifo_rd_eop,
  output logic [PORT_NUM-1:0]        fifo_rd_en,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic                       out_eop,
  input  logic                       out_ready,
  output logic                       pkt_busy,
  output logic                       pkt_done,
  output logic                       pkt_err
);

  localparam int IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int CNT_W = $clog2(MAX_LEN) + 1;
  localparam logic [7:0] PORT_LIM = 8'(PORT_NUM);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  cur_idx;
  logic [CNT_W-1:0]  word_cnt;

  logic              sel_in_range;
  logic              sel_take;
  logic              sel_bad;
  logic              head_empty;
  logic              head_eop;
  logic [DATA_W-1:0] head_data;
  logic              pop;
  logic              last_word;
  logic              pkt_end;

  assign sel_in_range = {1'b0, fifo_sel_res_final[6:0]} < PORT_LIM;
  assign sel_take = (state == IDLE) && fifo_sel_res_final[7]
                    && sel_in_range;
  assign sel_bad  = (state == IDLE) && fifo_sel_res_final[7]
                    && !sel_in_range;

  always_comb begin
    head_empty = 1'b1;
    head_eop   = 1'b0;
    head_data  = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (cur_idx == IDX_W'(i)) begin
        head_empty = fifo_empty[i];
        head_eop   = fifo_rd_eop[i];
        head_data  = fifo_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pop only when the output register is free or draining this cycle.
  assign pop = (state == XFER) && !head_empty
               && (!out_valid || out_ready);
  assign last_word = (word_cnt == LAST_CNT);
  assign pkt_end = pop && (head_eop || last_word);

  always_comb begin
    fifo_rd_en = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      fifo_rd_en[i] = pop && (cur_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sel_take) state_nxt = XFER;
      XFER:    if (pkt_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pkt_busy = (state != IDLE);

  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      state     <= IDLE;
      cur_idx   <= '0;
      word_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_eop   <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sel_take) cur_idx <= fifo_sel_res_final[IDX_W-1:0];
      if (pkt_end) word_cnt <= '0;
      else if (pop) word_cnt <= word_cnt + 1'b1;
      if (pop) begin
        out_data  <= head_data;
        out_eop   <= head_eop || last_word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      pkt_done <= pkt_end;
      // Overrun truncates the packet: flagged as error and as done.
      pkt_err  <= sel_bad || (pop && last_word && !head_eop);
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: FIFO models, output scoreboard, selection vector table
// and hand-written packet sequences for fifo_rd_ctrl.
module tb_fifo_rd_ctrl;

  localparam int PN = 14;
  localparam int DW = 32;
  localparam int ML = 256;

  logic              glb_clk = 1'b0;
  logic              glb_areset_n;
  logic [7:0]        sel;
  logic [PN-1:0]     fifo_empty = '1;
  logic [PN*DW-1:0]  fifo_rd_data = '0;
  logic [PN-1:0]     fifo_rd_eop = '0;
  logic [PN-1:0]     fifo_rd_en;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_eop;
  logic              out_ready;
  logic              pkt_busy;
  logic              pkt_done;
  logic              pkt_err;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  logic [DW:0]   fq [PN][$];
  logic [DW:0]   sb [$];
  bit            sb_en;
  logic [PN-1:0] pop_pend = '0;

  typedef struct packed {
    logic [7:0] sel;
    logic       busy;
    logic       err;
  } vec_t;

  fifo_rd_ctrl #(.PORT_NUM(PN), .DATA_W(DW), .MAX_LEN(ML)) dut (
    .glb_clk            (glb_clk),
    .glb_areset_n       (glb_areset_n),
    .fifo_sel_res_final (sel),
    .fifo_empty         (fifo_empty),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_eop        (fifo_rd_eop),
    .fifo_rd_en         (fifo_rd_en),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_eop            (out_eop),
    .out_ready          (out_ready),
    .pkt_busy           (pkt_busy),
    .pkt_done           (pkt_done),
    .pkt_err            (pkt_err)
  );

  always #5 glb_clk = ~glb_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // FIFO models: pop what the DUT strobed, present the new head.
  always @(posedge glb_clk) begin
    for (int i = 0; i < PN; i++) begin
      logic [DW:0] hd;
      if (glb_areset_n && pop_pend[i] && fq[i].size() > 0)
        void'(fq[i].pop_front());
      if (fq[i].size() > 0) begin
        hd = fq[i][0];
        fifo_empty[i] <= 1'b0;
        fifo_rd_eop[i] <= hd[DW];
        fifo_rd_data[i*DW +: DW] <= hd[DW-1:0];
      end else begin
        fifo_empty[i] <= 1'b1;
        fifo_rd_eop[i] <= 1'b0;
        fifo_rd_data[i*DW +: DW] <= '0;
      end
    end
  end

  // Monitor: pop legality and output scoreboard.
  always @(negedge glb_clk) begin
    logic [DW:0] exp;
    pop_pend <= fifo_rd_en;
    if (glb_areset_n && pkt_done) done_cnt++;
    if (glb_areset_n && fifo_rd_en != '0) begin
      chk("rd_en_onehot", $countones(fifo_rd_en), 1);
      chk("pop_while_stalled", out_valid && !out_ready, 0);
      chk("pop_from_empty", |(fifo_rd_en & fifo_empty), 0);
    end
    if (sb_en && glb_areset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra_word", sb.size(), 1);
      end else begin
        exp = sb.pop_front();
        chk("out_word", {out_eop, out_data}, exp);
      end
    end
  end

  task automatic tick;
    @(posedge glb_clk);
    #1;
  endtask

  task automatic load(input int p, input int n, input int base,
                      input bit to_sb);
    logic [DW:0] w;
    for (int k = 0; k < n; k++) begin
      w = {k == n - 1, DW'(base + k)};
      fq[p].push_back(w);
      if (to_sb) sb.push_back(w);
    end
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge glb_clk);
      ok = pkt_done;
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge glb_clk);
      ok = !pkt_busy && !out_valid;
    end
  endtask

  initial begin
    vec_t tbl [7];
    bit ok;
    int d0;

    tbl[0] = '{sel: 8'd0,   busy: 1'b0, err: 1'b0};
    tbl[1] = '{sel: 8'd13,  busy: 1'b0, err: 1'b0};
    tbl[2] = '{sel: 8'd128, busy: 1'b1, err: 1'b0};
    tbl[3] = '{sel: 8'd141, busy: 1'b1, err: 1'b0};
    tbl[4] = '{sel: 8'd142, busy: 1'b0, err: 1'b1};
    tbl[5] = '{sel: 8'd143, busy: 1'b0, err: 1'b1};
    tbl[6] = '{sel: 8'd255, busy: 1'b0, err: 1'b1};

    glb_areset_n = 1'b0;
    sel = 8'd0;
    out_ready = 1'b1;
    sb_en = 1'b1;

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", pkt_busy, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_err", pkt_err, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    tick;
    glb_areset_n = 1'b1;

    // Selection decode, all FIFOs empty.
    for (int i = 0; i < 7; i++) begin
      tick;
      sel = tbl[i].sel;
      tick;
      sel = 8'd0;
      @(negedge glb_clk);
      chk("tbl_busy", pkt_busy, tbl[i].busy);
      chk("tbl_err", pkt_err, tbl[i].err);
      chk("tbl_rd_en", fifo_rd_en, 0);
      @(negedge glb_clk);
      chk("tbl_err_pulse", pkt_err, 0);
      glb_areset_n = 1'b0;
      tick;
      glb_areset_n = 1'b1;
    end
    tick;

    // 4-word packet from FIFO3 at full rate.
    load(3, 4, 32'h300, 1'b1);
    sel = 8'd131;
    @(negedge glb_clk);
    chk("f3_pre_rd_en", fifo_rd_en, 0);
    tick;
    sel = 8'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge glb_clk);
      chk("f3_rd_en", fifo_rd_en, 14'h0008);
      chk("f3_valid", out_valid, k > 0);
    end
    @(negedge glb_clk);
    chk("f3_rd_en_end", fifo_rd_en, 0);
    chk("f3_done", pkt_done, 1);
    chk("f3_eop", out_eop, 1);
    chk("f3_err", pkt_err, 0);
    @(negedge glb_clk);
    chk("f3_done_pulse", pkt_done, 0);
    chk("f3_idle", pkt_busy, 0);
    tick;
    chk("f3_drained", fq[3].size(), 0);
    chk("f3_sb_empty", sb.size(), 0);

    // Same packet with backpressure.
    d0 = done_cnt;
    load(3, 4, 32'h310, 1'b1);
    sel = 8'd131;
    tick;
    sel = 8'd0;
    for (int k = 0; k < 10; k++) begin
      out_ready = (k % 2 == 0);
      tick;
    end
    out_ready = 1'b1;
    wait_idle(20, ok);
    chk("bp_idle", ok, 1);
    chk("bp_done_cnt", done_cnt - d0, 1);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_drained", fq[3].size(), 0);

    // Overrun: 300 words, no eop, on FIFO0.
    tick;
    for (int k = 0; k < 300; k++)
      fq[0].push_back({1'b0, DW'(32'h1000 + k)});
    for (int k = 0; k < ML; k++)
      sb.push_back({k == ML - 1, DW'(32'h1000 + k)});
    sel = 8'd128;
    tick;
    sel = 8'd0;
    wait_done(400, ok);
    chk("ovr_done_seen", ok, 1);
    chk("ovr_err_with_done", pkt_err, 1);
    chk("ovr_eop_forced", out_eop, 1);
    wait_idle(10, ok);
    chk("ovr_idle", ok, 1);
    chk("ovr_err_pulse", pkt_err, 0);
    chk("ovr_left", fq[0].size(), 44);
    chk("ovr_sb_empty", sb.size(), 0);
    fq[0].delete();
    tick;

    // Reset after 2 of 5 words from FIFO7.
    sb_en = 1'b0;
    load(7, 5, 32'h700, 1'b0);
    sel = 8'd135;
    tick;
    sel = 8'd0;
    @(posedge glb_clk);
    @(posedge glb_clk);
    #2;
    glb_areset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_eop", out_eop, 0);
    chk("mid_rst_busy", pkt_busy, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    chk("mid_rst_left", fq[7].size(), 3);
    tick;
    tick;
    glb_areset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge glb_clk);
      chk("post_rst_rd_en", fifo_rd_en, 0);
      chk("post_rst_busy", pkt_busy, 0);
    end
    chk("post_rst_left", fq[7].size(), 3);
    fq[7].delete();
    sb.delete();
    tick;
    sb_en = 1'b1;

    // Selection change mid-packet: FIFO2 finishes before FIFO5.
    load(2, 3, 32'h200, 1'b1);
    load(5, 2, 32'h500, 1'b1);
    sel = 8'd130;
    tick;
    sel = 8'd133;
    wait_done(20, ok);
    chk("sw_done1", ok, 1);
    chk("sw_f2_drained", fq[2].size(), 0);
    chk("sw_f5_untouched", fq[5].size(), 2);
    @(negedge glb_clk);
    chk("sw_gap_idle", pkt_busy, 0);
    chk("sw_gap_rd_en", fifo_rd_en, 0);
    @(negedge glb_clk);
    chk("sw_f5_rd_en", fifo_rd_en, 14'h0020);
    wait_done(20, ok);
    chk("sw_done2", ok, 1);
    sel = 8'd0;
    wait_idle(10, ok);
    chk("sw_idle", ok, 1);
    chk("sw_f5_drained", fq[5].size(), 0);
    chk("sw_sb_empty", sb.size(), 0);

    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
